// File: rtl/sos_pkg.sv
// Shared types for the SOS decision stage.
//   sos_state_t : match-progress FSM states (2-bit encoding, value 3 unused)
//   sym_t       : classification of a completed character
package sos_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    GOT_S  = 2'd1,
    GOT_SO = 2'd2
  } sos_state_t;

  typedef enum logic [1:0] {
    SYM_S = 2'd0,
    SYM_O = 2'd1,
    SYM_X = 2'd2
  } sym_t;

  function automatic sym_t classify(input logic is_s, input logic is_o);
    if (is_s && !is_o) return SYM_S;
    if (is_o && !is_s) return SYM_O;
    return SYM_X;
  endfunction

endpackage

// File: rtl/sos_sequence_detector.sv
// S-O-S sequence detector: consumes per-character strobes from the S/O
// character detectors and reports each (overlapping) S-O-S match.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   clr       : synchronous clear of FSM, gap counter and match count
//   cb        : 1-cycle character-boundary strobe; is_s/is_o valid with it
//   is_s/is_o : completed character is S / O
//   sos_found : 1-cycle pulse, S-O-S completed
//   timeout   : 1-cycle pulse, partial match abandoned after an idle gap
//   sym_err   : 1-cycle pulse, cb with both is_s and is_o set
//   sos_count : saturating count of matches since reset/clr
//   state     : current FSM state (debug)
module sos_sequence_detector
  import sos_pkg::*;
#(
  parameter int unsigned GAP_MAX = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cb,
  input  logic             is_s,
  input  logic             is_o,
  output logic             sos_found,
  output logic             timeout,
  output logic             sym_err,
  output logic [CNT_W-1:0] sos_count,
  output logic [1:0]       state
);

  localparam int unsigned GAP_W = $clog2(GAP_MAX + 1);
  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(GAP_MAX);
  localparam logic [GAP_W-1:0] GAP_TO  = GAP_W'(GAP_MAX - 1);

  sos_state_t       state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             found_q, found_d;
  logic             tmo_q, tmo_d;
  logic             err_q, err_d;
  sym_t             sym;

  always_comb begin
    sym     = classify(is_s, is_o);
    state_d = state_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    found_d = 1'b0;
    tmo_d   = 1'b0;
    err_d   = 1'b0;

    if (clr) begin
      // Clear wins over a coincident cb: the character is dropped entirely.
      state_d = IDLE;
      gap_d   = '0;
      cnt_d   = '0;
    end else if (cb) begin
      gap_d = '0;
      err_d = is_s & is_o;
      case (state_q)
        IDLE:    state_d = (sym == SYM_S) ? GOT_S : IDLE;
        GOT_S: begin
          case (sym)
            SYM_S:   state_d = GOT_S;
            SYM_O:   state_d = GOT_SO;
            default: state_d = IDLE;
          endcase
        end
        GOT_SO: begin
          if (sym == SYM_S) begin
            // The closing S also opens the next match (overlap).
            state_d = GOT_S;
            found_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      if (gap_q != GAP_LIM) gap_d = gap_q + 1'b1;
      if (state_q != IDLE && gap_q == GAP_TO) begin
        state_d = IDLE;
        tmo_d   = 1'b1;
      end else if (state_q != GOT_S && state_q != GOT_SO) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign sos_found = found_q;
  assign timeout   = tmo_q;
  assign sym_err   = err_q;
  assign sos_count = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_sos_sequence_detector.sv
module tb_sos_sequence_detector;

  localparam int unsigned GAP_MAX = 16;

  logic       clk = 1'b0;
  logic       rst_n, clr, cb, is_s, is_o;
  logic       found, tmo, err;
  logic [7:0] count;
  logic [1:0] st;
  logic       found2, tmo2, err2;
  logic [1:0] count2;
  logic [1:0] st2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sos_sequence_detector #(.GAP_MAX(GAP_MAX), .CNT_W(8)) dut (
    .clk(clk), .rst(rst_n), .clr(clr), .cb(cb), .is_s(is_s), .is_o(is_o),
    .sos_found(found), .timeout(tmo), .sym_err(err), .sos_count(count), .state(st)
  );

  sos_sequence_detector #(.GAP_MAX(GAP_MAX), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst_n), .clr(clr), .cb(cb), .is_s(is_s), .is_o(is_o),
    .sos_found(found2), .timeout(tmo2), .sym_err(err2), .sos_count(count2), .state(st2)
  );

  typedef struct {
    logic       cb, s, o, clr;
    logic [1:0] st;
    logic       f, t, e;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic c, input logic s, input logic o, input logic cl,
                     input logic [1:0] es, input logic ef, input logic et,
                     input logic ee, input logic [7:0] ec);
    vec_t v;
    v.cb = c; v.s = s; v.o = o; v.clr = cl;
    v.st = es; v.f = ef; v.t = et; v.e = ee; v.cnt = ec;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic c, input logic s, input logic o, input logic cl);
    cb = c; is_s = s; is_o = o; clr = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic check_all(input string tag, input logic [1:0] es, input logic ef,
                           input logic et, input logic ee, input logic [7:0] ec);
    check({tag, ".state"}, 32'(st), 32'(es));
    check({tag, ".sos_found"}, 32'(found), 32'(ef));
    check({tag, ".timeout"}, 32'(tmo), 32'(et));
    check({tag, ".sym_err"}, 32'(err), 32'(ee));
    check({tag, ".sos_count"}, 32'(count), 32'(ec));
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; clr = 1'b0; cb = 1'b0; is_s = 1'b0; is_o = 1'b0;
    do_reset();
    check_all("reset", 2'd0, 0, 0, 0, 8'd0);

    // Asynchronous reset while in GOT_SO with a nonzero count.
    step(1, 1, 0, 0); step(1, 0, 1, 0); step(1, 1, 0, 0); step(1, 0, 1, 0);
    check_all("pre_rst", 2'd2, 0, 0, 0, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 2'd0, 0, 0, 0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0);

    // Directed vector table: inputs for one cycle, outputs after that edge.
    // S-O-S with a cb every 4 cycles
    add(1,1,0,0, 2'd1,0,0,0,8'd0);
    add(0,0,0,0, 2'd1,0,0,0,8'd0);
    add(0,0,0,0, 2'd1,0,0,0,8'd0);
    add(0,0,0,0, 2'd1,0,0,0,8'd0);
    add(1,0,1,0, 2'd2,0,0,0,8'd0);
    add(0,0,0,0, 2'd2,0,0,0,8'd0);
    add(0,0,0,0, 2'd2,0,0,0,8'd0);
    add(0,0,0,0, 2'd2,0,0,0,8'd0);
    add(1,1,0,0, 2'd1,1,0,0,8'd1);
    add(0,0,0,0, 2'd1,0,0,0,8'd1);
    add(0,0,0,0, 2'd1,0,0,0,8'd1);
    add(0,0,0,1, 2'd0,0,0,0,8'd0);
    // S,O,S,O,S overlapping -> 2 matches
    add(1,1,0,0, 2'd1,0,0,0,8'd0);
    add(1,0,1,0, 2'd2,0,0,0,8'd0);
    add(1,1,0,0, 2'd1,1,0,0,8'd1);
    add(1,0,1,0, 2'd2,0,0,0,8'd1);
    add(1,1,0,0, 2'd1,1,0,0,8'd2);
    add(0,0,0,0, 2'd1,0,0,0,8'd2);
    add(0,0,0,1, 2'd0,0,0,0,8'd0);
    // S,S,O,S -> 1 match
    add(1,1,0,0, 2'd1,0,0,0,8'd0);
    add(1,1,0,0, 2'd1,0,0,0,8'd0);
    add(1,0,1,0, 2'd2,0,0,0,8'd0);
    add(1,1,0,0, 2'd1,1,0,0,8'd1);
    add(0,0,0,0, 2'd1,0,0,0,8'd1);
    // is_s=is_o=1 in GOT_S, then in IDLE; O in IDLE
    add(1,1,1,0, 2'd0,0,0,1,8'd1);
    add(0,0,0,0, 2'd0,0,0,0,8'd1);
    add(1,0,1,0, 2'd0,0,0,0,8'd1);
    add(1,1,1,0, 2'd0,0,0,1,8'd1);
    // X (neither) in GOT_SO and in GOT_S
    add(1,1,0,0, 2'd1,0,0,0,8'd1);
    add(1,0,1,0, 2'd2,0,0,0,8'd1);
    add(1,0,0,0, 2'd0,0,0,0,8'd1);
    add(1,1,0,0, 2'd1,0,0,0,8'd1);
    add(1,0,0,0, 2'd0,0,0,0,8'd1);
    // clr coincident with the closing S
    add(1,1,0,0, 2'd1,0,0,0,8'd1);
    add(1,0,1,0, 2'd2,0,0,0,8'd1);
    add(1,1,0,1, 2'd0,0,0,0,8'd0);
    add(0,0,0,0, 2'd0,0,0,0,8'd0);
    // clr suppresses sym_err
    add(1,1,1,1, 2'd0,0,0,0,8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].cb, vecs[i].s, vecs[i].o, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].f, vecs[i].t, vecs[i].e, vecs[i].cnt);
    end

    // Gap: S then GAP_MAX-1 idle cycles holds; the next idle cycle times out.
    step(1, 1, 0, 0);
    for (int i = 0; i < GAP_MAX - 1; i++) step(0, 0, 0, 0);
    check_all("gap_hold", 2'd1, 0, 0, 0, 8'd0);
    step(0, 0, 0, 0);
    check_all("gap_timeout", 2'd0, 0, 1, 0, 8'd0);
    step(0, 0, 0, 0);
    check("gap_tmo_pulse_end", 32'(tmo), 32'd0);
    pulses = 0;
    for (int i = 0; i < 3 * GAP_MAX; i++) begin
      step(0, 0, 0, 0);
      if (tmo) pulses++;
    end
    check("idle_no_timeout", 32'(pulses), 32'd0);

    // Gap: cb arriving on the last allowed cycle beats the timeout.
    step(1, 1, 0, 0);
    for (int i = 0; i < GAP_MAX - 1; i++) step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    check_all("gap_cb_wins", 2'd2, 0, 0, 0, 8'd0);
    step(1, 1, 0, 0);
    check_all("gap_then_match", 2'd1, 1, 0, 0, 8'd1);

    // Saturation with a 2-bit counter: 5 matches, count sticks at 3.
    do_reset();
    check("sat_reset", 32'(count2), 32'd0);
    pulses = 0;
    step(1, 1, 0, 0);
    for (int m = 1; m <= 5; m++) begin
      step(1, 0, 1, 0);
      step(1, 1, 0, 0);
      if (found2) pulses++;
      check($sformatf("sat_count%0d", m), 32'(count2), (m > 3) ? 32'd3 : 32'(m));
    end
    step(0, 0, 0, 0);
    check("sat_pulses", 32'(pulses), 32'd5);
    check("sat_hold", 32'(count2), 32'd3);
    check("sat_wide_count", 32'(count), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
